// File: rtl/bypass_pkg.sv
// Shared selection-code constants and the priority-pick helper used by the
// operand bypass mux and its combinational selector.
package bypass_pkg;

    // Largest supported source count; the helper works on a vector this wide.
    localparam int MAX_NSRC = 8;

    // Codes above the per-source range, expressed as offsets from NSRC.
    localparam int SRC_DEFAULT_OFS = 0;
    localparam int SRC_ZERO_OFS    = 1;

    // Index of the lowest set bit among the first nsrc bits, or nsrc when none.
    function automatic logic [3:0] prio_first(input logic [MAX_NSRC-1:0] req,
                                              input int nsrc);
        logic [3:0] idx;
        idx = 4'(nsrc);
        for (int i = MAX_NSRC - 1; i >= 0; i--) begin
            if (i < nsrc && req[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bypass_prio_sel.sv
// Combinational priority selector: picks zero, the first hitting bypass
// source, or the register-file value, and flags multiple simultaneous hits.
module bypass_prio_sel
    import bypass_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SW    = $clog2(NSRC + 2)
) (
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [WIDTH-1:0]      dflt_data,
    input  logic                  zero_force,
    output logic [WIDTH-1:0]      sel_data,
    output logic [SW-1:0]         sel_code,
    output logic                  sel_multi
);

    logic [MAX_NSRC-1:0] req_ext;
    logic [3:0]          first;
    logic [3:0]          hits;

    always_comb begin
        req_ext = '0;
        req_ext[NSRC-1:0] = req;
        first = prio_first(req_ext, NSRC);

        hits = '0;
        for (int i = 0; i < NSRC; i++) begin
            hits = hits + 4'(req[i]);
        end
        // Multi-hit is reported even when the result is forced to zero.
        sel_multi = (hits >= 4'd2);

        sel_data = dflt_data;
        sel_code = SW'(NSRC + SRC_DEFAULT_OFS);
        if (zero_force) begin
            sel_data = '0;
            sel_code = SW'(NSRC + SRC_ZERO_OFS);
        end else if (first < 4'(NSRC)) begin
            sel_code = SW'(first);
            for (int i = 0; i < NSRC; i++) begin
                if (first == 4'(i)) begin
                    sel_data = src_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/operand_bypass_mux.sv
// Operand bypass mux with a registered valid/ready output stage.
// Define OPERAND_BYPASS_SKID_EN for a 2-entry (main + skid) stage with a registered in_ready.
module operand_bypass_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SW    = $clog2(NSRC + 2)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [WIDTH-1:0]      dflt_data,
    input  logic                  zero_force,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SW-1:0]         out_src,
    output logic                  out_multi
);

    // Handshake: a beat transfers on in_valid && in_ready && !flush at the
    // input and on out_valid && out_ready at the output; flush wins over both.

    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    sel_code;
    logic             sel_multi;
    logic             accept;

    bypass_prio_sel #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SW    (SW)
    ) u_sel (
        .req        (req),
        .src_data   (src_data),
        .dflt_data  (dflt_data),
        .zero_force (zero_force),
        .sel_data   (sel_data),
        .sel_code   (sel_code),
        .sel_multi  (sel_multi)
    );

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [SW-1:0]    main_src_q,   main_src_d;
    logic             main_multi_q, main_multi_d;

`ifdef OPERAND_BYPASS_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [SW-1:0]    skid_src_q,   skid_src_d;
    logic             skid_multi_q, skid_multi_d;
    logic             in_ready_q,   in_ready_d;
    logic             main_free;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q && !flush;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_src_d   = main_src_q;
        main_multi_d = main_multi_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_src_d   = skid_src_q;
        skid_multi_d = skid_multi_q;
        main_free    = !main_valid_q || out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Older skid beat moves up; a new beat (if any) refills skid.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_src_d   = skid_src_q;
                main_multi_d = skid_multi_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d  = sel_data;
                    skid_src_d   = sel_code;
                    skid_multi_d = sel_multi;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d  = sel_data;
                    main_src_d   = sel_code;
                    main_multi_d = sel_multi;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_data;
            skid_src_d   = sel_code;
            skid_multi_d = sel_multi;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_src_q   <= '0;
            skid_multi_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_src_q   <= skid_src_d;
            skid_multi_q <= skid_multi_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_src_d   = main_src_q;
        main_multi_d = main_multi_q;

        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = sel_data;
            main_src_d   = sel_code;
            main_multi_d = sel_multi;
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_src_q   <= '0;
            main_multi_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_src_q   <= main_src_d;
            main_multi_q <= main_multi_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_src   = main_src_q;
    assign out_multi = main_multi_q;

endmodule
